// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU data-in arbiter: FSM state encoding,
// the idle bus value and a lowest-set-bit search with a multi-hit flag.
package cpu_bus_pkg;

    localparam int MAX_CH = 32;

    // RST 38h opcode, returned whenever no device supplies data.
    localparam logic [7:0] DEFAULT_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CNT,
        WAIT_RDY,
        HOLD
    } arbState_t;

    typedef struct packed {
        logic [4:0] idx;
        logic       any;
        logic       multi;
    } prioHit_t;

    // Scans from the top so the lowest set bit is the one left in idx.
    function automatic prioHit_t lowestSet(input logic [MAX_CH-1:0] vec);
        prioHit_t r;
        int       cnt;
        r   = '0;
        cnt = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.idx = 5'(i);
                cnt++;
            end
        end
        r.any   = (cnt != 0);
        r.multi = (cnt > 1);
        return r;
    endfunction

endpackage

// File: rtl/cpu_di_arbiter_if.sv
// Bus bundle between the device/decoder side, the arbiter and the Z80 DI port.
interface cpu_di_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int WSW = 3
) ();
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cpu_rd;
    logic [NCH-1:0]   cs;
    logic [NCH*DW-1:0]  dev_data;
    logic [NCH*WSW-1:0] ws_cfg;
    logic [NCH-1:0]   dev_ready;
    logic [DW-1:0]    out_data;
    logic             cpu_wait_n;
    logic [IW-1:0]    sel_idx;
    logic             multi_sel_err;
    logic             timeout_err;

    // Arbiter side.
    modport slave (
        input  cpu_rd, cs, dev_data, ws_cfg, dev_ready,
        output out_data, cpu_wait_n, sel_idx, multi_sel_err, timeout_err
    );

    // CPU/device side.
    modport master (
        output cpu_rd, cs, dev_data, ws_cfg, dev_ready,
        input  out_data, cpu_wait_n, sel_idx, multi_sel_err, timeout_err
    );
endinterface

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 wins; also reports any/multiple hits.
module prio_enc
    import cpu_bus_pkg::*;
#(
    parameter int NCH = 4,
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    output logic [IW-1:0]  idx,
    output logic           any,
    output logic           multi
);
    logic [MAX_CH-1:0] reqPad;
    prioHit_t          hit;

    // Widen to the package search width and decode.
    always_comb begin
        reqPad = MAX_CH'(req);
        hit    = lowestSet(reqPad);
    end

    assign idx   = IW'(hit.idx);
    assign any   = hit.any;
    assign multi = hit.multi;
endmodule

// File: rtl/cpu_di_arbiter.sv
// Registered Z80 data-in arbiter: fixed-priority channel select, per-channel
// wait states, device-ready handshake with timeout, and WAIT generation.
module cpu_di_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int WSW = 3,
    parameter int TMO = 64,
    parameter logic [DW-1:0] DEFAULT_DATA = DW'(DEFAULT_BYTE)
) (
    input logic          clock,
    input logic          reset,
    cpu_di_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TMO + 1);

    arbState_t      state;
    logic [WSW-1:0] wcnt;
    logic [TW-1:0]  tcnt;
    logic [DW-1:0]  outData;
    logic           waitN;
    logic [IW-1:0]  selIdx;
    logic           multiErr;
    logic           tmoErr;

    logic [IW-1:0]  encIdx;
    logic           encAny;
    logic           encMulti;
    logic [IW-1:0]  chSel;
    logic [DW-1:0]  devWord [NCH];
    logic [WSW-1:0] wsWord  [NCH];
    logic [DW-1:0]  curData;
    logic [WSW-1:0] curWs;
    logic           curRdy;

    prio_enc #(.NCH(NCH)) u_prio (
        .req   (bus.cs),
        .idx   (encIdx),
        .any   (encAny),
        .multi (encMulti)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign devWord[i] = bus.dev_data[i*DW +: DW];
        assign wsWord[i]  = bus.ws_cfg[i*WSW +: WSW];
    end

    // Live encoder result only at the start edge; afterwards the latched channel.
    assign chSel   = (state == IDLE) ? encIdx : selIdx;
    assign curData = devWord[chSel];
    assign curWs   = wsWord[chSel];
    assign curRdy  = bus.dev_ready[chSel];

    // Read-cycle FSM with wait/timeout counters and registered bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            tcnt     <= '0;
            outData  <= DEFAULT_DATA;
            waitN    <= 1'b1;
            selIdx   <= '0;
            multiErr <= 1'b0;
            tmoErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    outData <= DEFAULT_DATA;
                    waitN   <= 1'b1;
                    tcnt    <= '0;
                    if (bus.cpu_rd) begin
                        if (!encAny) begin
                            state <= HOLD;
                        end else begin
                            selIdx <= encIdx;
                            wcnt   <= curWs;
                            if (encMulti) multiErr <= 1'b1;
                            if (curWs == '0 && curRdy) begin
                                outData <= curData;
                                state   <= HOLD;
                            end else if (curWs <= WSW'(1)) begin
                                // A count of 1 has already "reached 1": skip WAIT_CNT.
                                waitN <= 1'b0;
                                state <= WAIT_RDY;
                            end else begin
                                waitN <= 1'b0;
                                state <= WAIT_CNT;
                            end
                        end
                    end
                end
                WAIT_CNT: begin
                    if (!bus.cpu_rd) begin
                        outData <= DEFAULT_DATA;
                        waitN   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wcnt <= wcnt - WSW'(1);
                        if (wcnt == WSW'(2)) state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (!bus.cpu_rd) begin
                        outData <= DEFAULT_DATA;
                        waitN   <= 1'b1;
                        state   <= IDLE;
                    end else if (curRdy) begin
                        outData <= curData;
                        waitN   <= 1'b1;
                        state   <= HOLD;
                    end else if (tcnt == TW'(TMO - 1)) begin
                        outData <= DEFAULT_DATA;
                        tmoErr  <= 1'b1;
                        waitN   <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (!bus.cpu_rd) begin
                        outData <= DEFAULT_DATA;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data      = outData;
    assign bus.cpu_wait_n    = waitN;
    assign bus.sel_idx       = selIdx;
    assign bus.multi_sel_err = multiErr;
    assign bus.timeout_err   = tmoErr;
endmodule

// File: tb/tb_cpu_di_arbiter.sv
// Directed bench for cpu_di_arbiter: reset, zero-wait, wait states, ready
// handshake, timeout, priority/multi-select, no-select and abort.
module tb_cpu_di_arbiter;
    import cpu_bus_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    cpu_di_arbiter_if #(.NCH(4), .DW(8), .WSW(3)) bus ();

    cpu_di_arbiter #(
        .NCH(4), .DW(8), .WSW(3), .TMO(64), .DEFAULT_DATA(8'hFF)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWs(input int ch, input logic [2:0] val);
        bus.ws_cfg[ch*3 +: 3] = val;
    endtask

    // Counts sampled cycles with WAIT low until it is released again.
    task automatic measureWait(input int limit, output int lowCnt, output bit done);
        lowCnt = 0;
        done   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (!bus.cpu_wait_n) lowCnt++;
            else if (lowCnt > 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic endRead();
        bus.cpu_rd = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL reset_out_data got %h want ff", bus.out_data); end
        checks++; if (bus.cpu_wait_n !== 1'b1) begin fails++; $display("FAIL reset_wait_n got %b want 1", bus.cpu_wait_n); end
        checks++; if (bus.sel_idx !== 2'd0) begin fails++; $display("FAIL reset_sel_idx got %0d want 0", bus.sel_idx); end
        checks++; if ({bus.multi_sel_err, bus.timeout_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {bus.multi_sel_err, bus.timeout_err}); end
        rst = 1'b0;
        tick();
        // Reset arriving mid WAIT_CNT on ch2 with 7 wait states.
        bus.cs = 4'b0100;
        setWs(2, 3'd7);
        bus.cpu_rd = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (bus.cpu_wait_n !== 1'b0) begin fails++; $display("FAIL midreset_pre_wait got %b want 0", bus.cpu_wait_n); end
        rst = 1'b1;
        #1;
        checks++; if (bus.cpu_wait_n !== 1'b1) begin fails++; $display("FAIL midreset_wait_n got %b want 1", bus.cpu_wait_n); end
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL midreset_out_data got %h want ff", bus.out_data); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL midreset_state got %0d want %0d", dut.state, IDLE); end
        bus.cpu_rd = 1'b0;
        tick();
        rst = 1'b0;
        setWs(2, 3'd0);
        tick();
    endtask

    task automatic test_zero_wait();
        bus.cs = 4'b0001;
        setWs(0, 3'd0);
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'hC3) begin fails++; $display("FAIL zw_out_data got %h want c3", bus.out_data); end
        checks++; if (bus.cpu_wait_n !== 1'b1) begin fails++; $display("FAIL zw_wait_n got %b want 1", bus.cpu_wait_n); end
        checks++; if (bus.sel_idx !== 2'd0) begin fails++; $display("FAIL zw_sel_idx got %0d want 0", bus.sel_idx); end
        tick();
        checks++; if (bus.out_data !== 8'hC3) begin fails++; $display("FAIL zw_hold got %h want c3", bus.out_data); end
        bus.cpu_rd = 1'b0;
        tick();
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL zw_release got %h want ff", bus.out_data); end
        tick();
    endtask

    task automatic test_wait_states();
        int lowCnt;
        bit done;
        bus.cs = 4'b0100;
        setWs(2, 3'd3);
        bus.cpu_rd = 1'b1;
        tick();
        lowCnt = 1;
        checks++; if (bus.cpu_wait_n !== 1'b0) begin fails++; $display("FAIL ws_first_low got %b want 0", bus.cpu_wait_n); end
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL ws_data_during_wait got %h want ff", bus.out_data); end
        // Channel lock: a later cs change must not move the selection.
        bus.cs = 4'b0001;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.cpu_wait_n) lowCnt++;
            else begin done = 1'b1; break; end
        end
        checks++; if (!done) begin fails++; $display("FAIL ws_release_timeout got no release want release"); end
        checks++; if (lowCnt !== 3) begin fails++; $display("FAIL ws_low_cycles got %0d want 3", lowCnt); end
        checks++; if (bus.out_data !== 8'h5A) begin fails++; $display("FAIL ws_out_data got %h want 5a", bus.out_data); end
        checks++; if (bus.sel_idx !== 2'd2) begin fails++; $display("FAIL ws_sel_lock got %0d want 2", bus.sel_idx); end
        tick();
        tick();
        checks++; if (bus.out_data !== 8'h5A) begin fails++; $display("FAIL ws_hold got %h want 5a", bus.out_data); end
        bus.cpu_rd = 1'b0;
        tick();
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL ws_release_data got %h want ff", bus.out_data); end
        setWs(2, 3'd0);
        tick();
    endtask

    task automatic test_no_select();
        bus.cs = 4'b0000;
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL nosel_out_data got %h want ff", bus.out_data); end
        tick();
        checks++; if (bus.cpu_wait_n !== 1'b1) begin fails++; $display("FAIL nosel_wait_n got %b want 1", bus.cpu_wait_n); end
        endRead();
    endtask

    task automatic test_abort();
        bus.cs = 4'b0100;
        setWs(2, 3'd5);
        bus.cpu_rd = 1'b1;
        tick();
        tick();
        checks++; if (bus.cpu_wait_n !== 1'b0) begin fails++; $display("FAIL abort_pre_wait got %b want 0", bus.cpu_wait_n); end
        bus.cpu_rd = 1'b0;
        tick();
        checks++; if (bus.cpu_wait_n !== 1'b1) begin fails++; $display("FAIL abort_wait_n got %b want 1", bus.cpu_wait_n); end
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL abort_out_data got %h want ff", bus.out_data); end
        checks++; if ({bus.multi_sel_err, bus.timeout_err} !== 2'b00) begin fails++; $display("FAIL abort_flags got %b want 00", {bus.multi_sel_err, bus.timeout_err}); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL abort_state got %0d want %0d", dut.state, IDLE); end
        setWs(2, 3'd0);
        tick();
    endtask

    task automatic test_ready_handshake();
        int lowCnt;
        bit done;
        bus.cs = 4'b0010;
        setWs(1, 3'd0);
        bus.dev_ready[1] = 1'b0;
        bus.cpu_rd = 1'b1;
        lowCnt = 0;
        done   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!bus.cpu_wait_n) lowCnt++;
            else begin done = 1'b1; break; end
            if (k == 9) bus.dev_ready[1] = 1'b1;
        end
        checks++; if (!done) begin fails++; $display("FAIL rdy_release_timeout got no release want release"); end
        checks++; if (lowCnt !== 10) begin fails++; $display("FAIL rdy_low_cycles got %0d want 10", lowCnt); end
        checks++; if (bus.out_data !== 8'hA7) begin fails++; $display("FAIL rdy_out_data got %h want a7", bus.out_data); end
        checks++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL rdy_timeout_err got %b want 0", bus.timeout_err); end
        endRead();
    endtask

    task automatic test_timeout();
        int lowCnt;
        bit done;
        bus.cs = 4'b0010;
        bus.dev_ready[1] = 1'b0;
        bus.cpu_rd = 1'b1;
        measureWait(200, lowCnt, done);
        checks++; if (!done) begin fails++; $display("FAIL tmo_release_timeout got no release want release"); end
        checks++; if (lowCnt !== 64) begin fails++; $display("FAIL tmo_low_cycles got %0d want 64", lowCnt); end
        checks++; if (bus.out_data !== 8'hFF) begin fails++; $display("FAIL tmo_out_data got %h want ff", bus.out_data); end
        checks++; if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_flag got %b want 1", bus.timeout_err); end
        bus.dev_ready[1] = 1'b1;
        endRead();
    endtask

    task automatic test_priority();
        bus.cs = 4'b1010;
        setWs(1, 3'd0);
        setWs(3, 3'd0);
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.sel_idx !== 2'd1) begin fails++; $display("FAIL prio_sel_idx got %0d want 1", bus.sel_idx); end
        checks++; if (bus.out_data !== 8'hA7) begin fails++; $display("FAIL prio_out_data got %h want a7", bus.out_data); end
        checks++; if (bus.multi_sel_err !== 1'b1) begin fails++; $display("FAIL prio_multi got %b want 1", bus.multi_sel_err); end
        endRead();
        // Clean back-to-back reads after the error: flag must stay sticky.
        bus.cs = 4'b0001;
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'hC3) begin fails++; $display("FAIL b2b_first got %h want c3", bus.out_data); end
        bus.cpu_rd = 1'b0;
        tick();
        bus.cs = 4'b1000;
        bus.cpu_rd = 1'b1;
        tick();
        checks++; if (bus.out_data !== 8'h3C) begin fails++; $display("FAIL b2b_second got %h want 3c", bus.out_data); end
        checks++; if (bus.sel_idx !== 2'd3) begin fails++; $display("FAIL b2b_sel_idx got %0d want 3", bus.sel_idx); end
        checks++; if (bus.multi_sel_err !== 1'b1) begin fails++; $display("FAIL multi_sticky got %b want 1", bus.multi_sel_err); end
        endRead();
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.cpu_rd    = 1'b0;
        bus.cs        = 4'b0000;
        bus.dev_data  = {8'h3C, 8'h5A, 8'hA7, 8'hC3};
        bus.ws_cfg    = '0;
        bus.dev_ready = 4'b1111;

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_no_select();
        test_abort();
        test_ready_handshake();
        test_timeout();
        test_priority();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard stop in case a scenario ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout got stalled want completion");
        $fatal(1);
    end
endmodule
